rtc_read_sequencer: RTL and testbench



---
 rtl/rtc_read_sequencer.sv | 107 ++++++++++
 tb/tb_rtc_read_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rtc_read_sequencer.sv
// rtc_read_sequencer: sweeps 11 RTC registers over the muxed A/D bus and strobes each captured byte into the register file
module rtc_read_sequencer #(
  parameter int PHASE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rtc_cs_n,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic       rtc_ad,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in,
  output logic [7:0] address,
  output logic [7:0] data_vga,
  output logic       AoD
);
  localparam int CW = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ADDR, AHOLD, DATA, STROBE, DONE} state_t;
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       ad;
    logic       oe;
    logic       aod;
    logic [7:0] ad_out;
    logic [7:0] address;
    logic [7:0] data_vga;
  } out_t;
  localparam out_t OUT_RST = '{busy: 1'b0, done: 1'b0, cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad: 1'b1,
                               oe: 1'b0, aod: 1'b1, ad_out: 8'h00, address: 8'h00, data_vga: 8'h00};
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] reg_addr;
  out_t out_q, out_d;
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    idx_d = idx_q;
    unique case (state_q)
      IDLE: begin
        state_d = start ? ADDR : IDLE;
        idx_d = start ? 4'd0 : idx_q;
      end
      ADDR: begin
        state_d = cnt_q == LAST ? AHOLD : ADDR;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      end
      AHOLD: state_d = DATA;
      DATA: begin
        state_d = cnt_q == LAST ? STROBE : DATA;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      end
      STROBE: begin
        state_d = idx_q == 4'd10 ? DONE : ADDR;
        idx_d = idx_q == 4'd10 ? idx_q : idx_q + 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    reg_addr = idx_d < 4'd8 ? 8'h21 + {4'd0, idx_d} : 8'h39 + {4'd0, idx_d};
    out_d = OUT_RST;
    out_d.busy = state_d != IDLE;
    out_d.done = state_d == DONE;
    out_d.cs_n = !(state_d == ADDR || state_d == AHOLD || state_d == DATA);
    out_d.wr_n = state_d != ADDR;
    out_d.rd_n = state_d != DATA;
    out_d.ad = !(state_d == ADDR || state_d == AHOLD);
    out_d.oe = state_d == ADDR || state_d == AHOLD;
    out_d.aod = state_d != STROBE;
    out_d.ad_out = out_d.oe ? reg_addr : 8'h00;
    out_d.address = state_d == STROBE ? reg_addr : out_q.address;
    out_d.data_vga = state_d == STROBE ? rtc_ad_in : out_q.data_vga;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      out_q <= OUT_RST;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      out_q <= out_d;
    end
  end
  assign busy = out_q.busy;
  assign done = out_q.done;
  assign rtc_cs_n = out_q.cs_n;
  assign rtc_wr_n = out_q.wr_n;
  assign rtc_rd_n = out_q.rd_n;
  assign rtc_ad = out_q.ad;
  assign rtc_ad_oe = out_q.oe;
  assign rtc_ad_out = out_q.ad_out;
  assign address = out_q.address;
  assign data_vga = out_q.data_vga;
  assign AoD = out_q.aod;
endmodule

// File: tb/tb_rtc_read_sequencer.sv
// tb_rtc_read_sequencer: two sequencers (PHASE_CYCLES 10 and 2) checked each cycle against a timeline model of the sweep
module tb_rtc_read_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] rst = 2'b11;
  logic [1:0] st = 2'b00;
  logic [1:0] busy, done, cs_n, wr_n, rd_n, ad, oe, aod;
  logic [7:0] ad_out [2];
  logic [7:0] ad_in [2];
  logic [7:0] address [2];
  logic [7:0] data_vga [2];
  logic [7:0] latch [2];
  logic [7:0] noise [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] tbl [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
  logic [7:0] qa [$];
  logic [7:0] qd [$];
  int pass_n = 0, total_n = 0, cyc = 0;
  int off [2] = '{0, 0};
  int ns [2] = '{0, 0};
  int nd [2] = '{0, 0};
  bit armed = 1'b0;
  int sc, at, b0, b1, n1, qb;

  rtc_read_sequencer #(.PHASE_CYCLES(10)) u_p10 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .busy(busy[0]), .done(done[0]),
    .rtc_cs_n(cs_n[0]), .rtc_wr_n(wr_n[0]), .rtc_rd_n(rd_n[0]), .rtc_ad(ad[0]),
    .rtc_ad_out(ad_out[0]), .rtc_ad_oe(oe[0]), .rtc_ad_in(ad_in[0]),
    .address(address[0]), .data_vga(data_vga[0]), .AoD(aod[0])
  );
  rtc_read_sequencer #(.PHASE_CYCLES(2)) u_p2 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .busy(busy[1]), .done(done[1]),
    .rtc_cs_n(cs_n[1]), .rtc_wr_n(wr_n[1]), .rtc_rd_n(rd_n[1]), .rtc_ad(ad[1]),
    .rtc_ad_out(ad_out[1]), .rtc_ad_oe(oe[1]), .rtc_ad_in(ad_in[1]),
    .address(address[1]), .data_vga(data_vga[1]), .AoD(aod[1])
  );

  assign ad_in[0] = !rd_n[0] ? latch[0] ^ 8'h5A : noise[0];
  assign ad_in[1] = !rd_n[1] ? latch[1] ^ 8'h5A : noise[1];

  function automatic int pcv(int i);
    return i == 0 ? 10 : 2;
  endfunction

  function automatic int ph(int o, int p);
    int r;
    if (o == 0) return 0;
    if (o == 11 * (2 * p + 2) + 1) return 5;
    r = (o - 1) % (2 * p + 2);
    return r < p ? 1 : r == p ? 2 : r <= 2 * p ? 3 : 4;
  endfunction

  function automatic int kof(int o, int p);
    return (o - 1) / (2 * p + 2);
  endfunction

  function automatic int nxt(int i);
    if (rst[i]) return 0;
    if (off[i] == 0) return st[i] ? 1 : 0;
    return off[i] == 11 * (2 * pcv(i) + 2) + 1 ? 0 : off[i] + 1;
  endfunction

  function automatic logic [23:0] expv(int o, int p, logic [7:0] ma, logic [7:0] md);
    int s;
    s = ph(o, p);
    return {1'(!(s >= 1 && s <= 3)), 1'(s != 1), 1'(s != 3), 1'(!(s == 1 || s == 2)),
            1'(s == 1 || s == 2), 1'(s != 4), 1'(s != 0), 1'(s == 5), ma, md};
  endfunction

  task automatic check(input string name, input bit ok, input logic [63:0] got, input logic [63:0] exp);
    total_n++;
    if (ok) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic wait_done(input int i, input int lim, output int when);
    when = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (done[i]) begin
        when = cyc;
        break;
      end
    end
    check($sformatf("done_seen%0d", i), when >= 0, 64'(when), 64'd1);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      off[i] <= nxt(i);
      if (rst[i]) begin
        m_addr[i] <= 8'h00;
        m_data[i] <= 8'h00;
      end else if (ph(nxt(i), pcv(i)) == 4) begin
        m_addr[i] <= tbl[kof(nxt(i), pcv(i))];
        m_data[i] <= tbl[kof(nxt(i), pcv(i))] ^ 8'h5A;
      end
      if (!wr_n[i]) latch[i] <= ad_out[i];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) noise[i] <= 8'($urandom);
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("outs%0d", i),
              {cs_n[i], wr_n[i], rd_n[i], ad[i], oe[i], aod[i], busy[i], done[i], address[i], data_vga[i]}
                === expv(off[i], pcv(i), m_addr[i], m_data[i]),
              64'({cs_n[i], wr_n[i], rd_n[i], ad[i], oe[i], aod[i], busy[i], done[i], address[i], data_vga[i]}),
              64'(expv(off[i], pcv(i), m_addr[i], m_data[i])));
        if (ph(off[i], pcv(i)) == 1 || ph(off[i], pcv(i)) == 2)
          check($sformatf("ad_out%0d", i), ad_out[i] === tbl[kof(off[i], pcv(i))],
                64'(ad_out[i]), 64'(tbl[kof(off[i], pcv(i))]));
        else if (ph(off[i], pcv(i)) == 0)
          check($sformatf("ad_out_idle%0d", i), ad_out[i] === 8'h00, 64'(ad_out[i]), 64'd0);
        check($sformatf("guard%0d", i),
              !(oe[i] && !rd_n[i]) && !(!aod[i] && !cs_n[i]) && !(!wr_n[i] && !rd_n[i]),
              64'({oe[i], rd_n[i], wr_n[i], aod[i], cs_n[i]}), 64'b11111);
        if (!aod[i]) ns[i] <= ns[i] + 1;
        if (done[i]) nd[i] <= nd[i] + 1;
      end
      if (!aod[0]) begin
        qa.push_back(address[0]);
        qd.push_back(data_vga[0]);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_bus", {cs_n, wr_n, rd_n, ad} === 8'hFF, 64'({cs_n, wr_n, rd_n, ad}), 64'hFF);
    check("rst_ctl", {oe, busy, done} === 6'b0, 64'({oe, busy, done}), 64'h0);
    check("rst_aod", aod === 2'b11, 64'(aod), 64'h3);
    check("rst_regs", {address[0], data_vga[0], address[1], data_vga[1], ad_out[0], ad_out[1]} === 48'h0,
          64'({address[0], data_vga[0], address[1], data_vga[1], ad_out[0], ad_out[1]}), 64'h0);
    armed = 1'b1;
    rst = 2'b00;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    b0 = ns[0];
    b1 = ns[1];
    qb = qa.size();
    st = 2'b11;
    sc = cyc;
    @(negedge clk);
    st = 2'b00;
    wait_done(1, 100, at);
    check("p2_done_at", at - sc == 67, 64'(at - sc), 64'd67);
    #1;
    check("p2_strobes", ns[1] - b1 == 11, 64'(ns[1] - b1), 64'd11);
    wait_done(0, 300, at);
    check("p10_done_at", at - sc == 243, 64'(at - sc), 64'd243);
    #1;
    check("p10_strobes", qa.size() - qb == 11, 64'(qa.size() - qb), 64'd11);
    check("addr_first", qa[qb] === 8'h21, 64'(qa[qb]), 64'h21);
    check("addr_idx8", qa[qb + 8] === 8'h41, 64'(qa[qb + 8]), 64'h41);
    check("addr_last", qa[qb + 10] === 8'h43, 64'(qa[qb + 10]), 64'h43);
    check("data_first", qd[qb] === 8'h7B, 64'(qd[qb]), 64'h7B);
    check("data_second", qd[qb + 1] === 8'h78, 64'(qd[qb + 1]), 64'h78);
    check("data_last", qd[qb + 10] === 8'h19, 64'(qd[qb + 10]), 64'h19);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    b1 = ns[1];
    n1 = nd[1];
    st[1] = 1'b1;
    sc = cyc;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (24 + $urandom_range(0, 4)) @(negedge clk);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    wait_done(1, 100, at);
    check("restart_ignored", at - sc == 67, 64'(at - sc), 64'd67);
    st[1] = 1'b1;
    @(negedge clk);
    st[1] = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("one_done", nd[1] - n1 == 1, 64'(nd[1] - n1), 64'd1);
    check("eleven_strobes", ns[1] - b1 == 11, 64'(ns[1] - b1), 64'd11);
    check("idle_after_done", busy[1] === 1'b0, 64'(busy[1]), 64'd0);
    b0 = ns[0];
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (77 + $urandom_range(0, 9)) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check("abort_bus", {cs_n[0], rd_n[0], oe[0], aod[0], busy[0], done[0]} === 6'b110100,
          64'({cs_n[0], rd_n[0], oe[0], aod[0], busy[0], done[0]}), 64'b110100);
    check("abort_strobes", ns[0] - b0 == 3, 64'(ns[0] - b0), 64'd3);
    qb = qa.size();
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, 300, at);
    #1;
    check("resweep_first", qa[qb] === 8'h21, 64'(qa[qb]), 64'h21);
    check("resweep_count", qa.size() - qb == 11, 64'(qa.size() - qb), 64'd11);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      st[0] = $urandom_range(0, 15) == 0;
      st[1] = $urandom_range(0, 7) == 0;
      rst[0] = $urandom_range(0, 399) == 0;
      rst[1] = $urandom_range(0, 149) == 0;
    end
    @(negedge clk);
    st = 2'b00;
    rst = 2'b00;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
